// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - state_t  : arbiter FSM state (previous cycle's owner)
//   - owner_t  : master identifiers used for the idle tie-break
//   - DM_*     : DMType encodings shared with the data memory
//   - sat_inc  : saturating increment for the 4-bit burst counter
// -----------------------------------------------------------------------------
package dm_arb_pkg;

  // FSM state: who owned the memory port in the previous cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_D = 2'd2
  } state_t;

  // Master identifiers.
  typedef enum logic {
    OWNER_C = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  // DMType field width and encodings (byte/half/word, signed/unsigned).
  localparam int          DMT_W     = 3;
  localparam logic [2:0]  DM_BYTE   = 3'b000;
  localparam logic [2:0]  DM_HALF   = 3'b001;
  localparam logic [2:0]  DM_WORD   = 3'b010;
  localparam logic [2:0]  DM_BYTE_U = 3'b100;
  localparam logic [2:0]  DM_HALF_U = 3'b101;

  // Burst counter geometry.
  localparam int          CNT_W   = 4;
  localparam logic [3:0]  CNT_MAX = 4'd15;

  // Saturating increment: an uncontended owner may stream forever, so the
  // counter must stick at its maximum instead of wrapping back to 0.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return CNT_MAX;
    return v + 4'd1;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_arbiter_if
// Bundles the CPU request port, the debug request port and the data-memory
// port of the arbiter.
//
// Handshake (applies to both request ports):
//   A master raises x_req with x_we/x_addr/x_wdata/x_dmtype and holds all of
//   them stable until it sees x_gnt=1 in the same cycle. A cycle with
//   x_req=1 and x_gnt=1 is exactly one performed access; x_rdata is valid only
//   in that cycle. There is no queueing: an ungranted request is simply held.
//
// Modports:
//   slave  : the arbiter (consumes requests, drives grants and memory port)
//   master : the environment (drives requests and memory read data)
// -----------------------------------------------------------------------------
interface dm_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import dm_arb_pkg::*;

  // CPU load/store port
  logic             c_req;
  logic             c_we;
  logic [AW-1:0]    c_addr;
  logic [DW-1:0]    c_wdata;
  logic [DMT_W-1:0] c_dmtype;
  logic             c_gnt;
  logic [DW-1:0]    c_rdata;
  logic             cpu_stall;

  // Debug / loader port
  logic             d_req;
  logic             d_we;
  logic [AW-1:0]    d_addr;
  logic [DW-1:0]    d_wdata;
  logic [DMT_W-1:0] d_dmtype;
  logic             d_gnt;
  logic [DW-1:0]    d_rdata;

  // Data memory port (read is combinational in the memory)
  logic             m_we;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic [DMT_W-1:0] m_dmtype;
  logic [DW-1:0]    m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_dmtype,
    output c_gnt, c_rdata, cpu_stall,
    input  d_req, d_we, d_addr, d_wdata, d_dmtype,
    output d_gnt, d_rdata,
    output m_we, m_addr, m_wdata, m_dmtype,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_dmtype,
    input  c_gnt, c_rdata, cpu_stall,
    output d_req, d_we, d_addr, d_wdata, d_dmtype,
    input  d_gnt, d_rdata,
    input  m_we, m_addr, m_wdata, m_dmtype,
    output m_rdata
  );

endinterface

// File: rtl/dm_port_mux.sv
// -----------------------------------------------------------------------------
// dm_port_mux
// Purely combinational select of the memory-side command {we, addr, wdata,
// dmtype} from the granted master. With no grant every output is zero, so
// an ungranted write can never reach the memory.
//
// Ports:
//   gnt_c_i, gnt_d_i          grant vector (at most one high)
//   c_*_i                     CPU command
//   d_*_i                     debug command
//   m_we_o, m_addr_o,
//   m_wdata_o, m_dmtype_o     selected command toward the data memory
// -----------------------------------------------------------------------------
module dm_port_mux
  import dm_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic             gnt_c_i,
  input  logic             gnt_d_i,
  input  logic             c_we_i,
  input  logic [AW-1:0]    c_addr_i,
  input  logic [DW-1:0]    c_wdata_i,
  input  logic [DMT_W-1:0] c_dmtype_i,
  input  logic             d_we_i,
  input  logic [AW-1:0]    d_addr_i,
  input  logic [DW-1:0]    d_wdata_i,
  input  logic [DMT_W-1:0] d_dmtype_i,
  output logic             m_we_o,
  output logic [AW-1:0]    m_addr_o,
  output logic [DW-1:0]    m_wdata_o,
  output logic [DMT_W-1:0] m_dmtype_o
);

  always_comb begin
    m_we_o     = 1'b0;
    m_addr_o   = '0;
    m_wdata_o  = '0;
    m_dmtype_o = '0;
    if (gnt_c_i) begin
      m_we_o     = c_we_i;
      m_addr_o   = c_addr_i;
      m_wdata_o  = c_wdata_i;
      m_dmtype_o = c_dmtype_i;
    end else if (gnt_d_i) begin
      m_we_o     = d_we_i;
      m_addr_o   = d_addr_i;
      m_wdata_o  = d_wdata_i;
      m_dmtype_o = d_dmtype_i;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares the single data-memory port between the pipeline CPU load/store
// port and a debug/loader master. One master is granted per cycle with zero
// latency (access performed in the same cycle as req and gnt). Under
// contention the current owner keeps the port for at most MAX_BURST
// consecutive cycles; from IDLE the master that did not go last wins.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; grants and m_we are held low
//                in any cycle where rst=1
//   bus          dm_arbiter_if.slave: CPU port, debug port, memory port
//   dbg_state_o  current FSM state (previous cycle's owner)
//   dbg_cnt_o    consecutive-grant counter of the current owner
//
// Parameters:
//   AW, DW       address / data width
//   MAX_BURST    contended burst limit, legal range 1..15
// -----------------------------------------------------------------------------
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  dm_arbiter_if.slave      bus,
  output state_t           dbg_state_o,
  output logic [CNT_W-1:0] dbg_cnt_o
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_t           rr_last_q, rr_last_d;

  logic gnt_c, gnt_d;

  // ---------------------------------------------------------------------------
  // Grant decision and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_c     = 1'b0;
    gnt_d     = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;

    if (!rst) begin
      if (bus.c_req && !bus.d_req) begin
        gnt_c = 1'b1;
      end else if (!bus.c_req && bus.d_req) begin
        gnt_d = 1'b1;
      end else if (bus.c_req && bus.d_req) begin
        case (state_q)
          // Owner keeps the port until it has used up its burst budget.
          OWN_C: begin
            if (cnt_q < BURST_LIM) gnt_c = 1'b1;
            else                   gnt_d = 1'b1;
          end
          OWN_D: begin
            if (cnt_q < BURST_LIM) gnt_d = 1'b1;
            else                   gnt_c = 1'b1;
          end
          // From IDLE the master that did not go last wins the tie.
          default: begin
            if (rr_last_q == OWNER_D) gnt_c = 1'b1;
            else                      gnt_d = 1'b1;
          end
        endcase
      end
    end

    if (gnt_c) begin
      state_d   = OWN_C;
      rr_last_d = OWNER_C;
      cnt_d     = (state_q == OWN_C) ? sat_inc(cnt_q) : 4'd1;
    end else if (gnt_d) begin
      state_d   = OWN_D;
      rr_last_d = OWNER_D;
      cnt_d     = (state_q == OWN_D) ? sat_inc(cnt_q) : 4'd1;
    end else begin
      // Idle cycle: forget the burst, keep the tie-break history.
      state_d   = IDLE;
      cnt_d     = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_last_q <= OWNER_D;   // CPU wins the first tie after reset
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-side command select
  // ---------------------------------------------------------------------------
  dm_port_mux #(
    .AW (AW),
    .DW (DW)
  ) u_port_mux (
    .gnt_c_i    (gnt_c),
    .gnt_d_i    (gnt_d),
    .c_we_i     (bus.c_we),
    .c_addr_i   (bus.c_addr),
    .c_wdata_i  (bus.c_wdata),
    .c_dmtype_i (bus.c_dmtype),
    .d_we_i     (bus.d_we),
    .d_addr_i   (bus.d_addr),
    .d_wdata_i  (bus.d_wdata),
    .d_dmtype_i (bus.d_dmtype),
    .m_we_o     (bus.m_we),
    .m_addr_o   (bus.m_addr),
    .m_wdata_o  (bus.m_wdata),
    .m_dmtype_o (bus.m_dmtype)
  );

  // ---------------------------------------------------------------------------
  // Grant / read-data / stall outputs
  // ---------------------------------------------------------------------------
  assign bus.c_gnt     = gnt_c;
  assign bus.d_gnt     = gnt_d;
  // Read data is broadcast; each master only trusts it in its granted cycle.
  assign bus.c_rdata   = bus.m_rdata;
  assign bus.d_rdata   = bus.m_rdata;
  assign bus.cpu_stall = bus.c_req & ~gnt_c;

  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule
